quantum_scheduler: RTL
======================

# quantum_scheduler

Preemptive round-robin scheduler for the five user-program slots in instruction RAM. It counts retired user instructions against a fixed quantum and raises an interrupt to vector the CPU into the context-switch routine at address 0. It also selects the next process and publishes the relocation base that the fetch path adds to the program counter. It sits between the CPU control unit and the instruction-RAM address path.

## Interface
Parameters:
- NUM_PROCS, 5, number of user-program slots
- PID_WIDTH, 3, width of process IDs
- QUANTUM, 1000, retired instructions per time slice (≥1)
- ADDR_WIDTH, 32, width of base_addr
- QW, $clog2(QUANTUM+1), width of quantum_left

Ports (clock, reset first):
- clock  in  1  single system clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  OS requests start of scheduling; sampled only in IDLE
- proc_valid  in  NUM_PROCS  slot loaded mask; captured into alive mask on leaving IDLE
- instr_retire  in  1  one-cycle pulse per retired user instruction
- proc_exit  in  1  current process halted; clears its alive bit
- irq_ack  in  1  CPU accepted interrupt
- cs_done  in  1  context-switch routine finished
- irq  out  1  interrupt request to CPU, level, held until irq_ack
- user_mode  out  1  high while a user process runs
- cur_pid  out  PID_WIDTH  running process
- next_pid  out  PID_WIDTH  process to be loaded by the context-switch routine
- base_addr  out  ADDR_WIDTH  relocation base for fetch
- quantum_left  out  QW  remaining instructions in the slice
- all_done  out  1  one-cycle pulse when the last alive process exits

## Operation
- States: IDLE, IRQ, SWITCH, RUN. The reset state is IDLE.
- Alive mask: internal NUM_PROCS bits. Loaded from proc_valid on IDLE→IRQ. Bit cur_pid cleared on proc_exit in RUN.
- Picker: first alive pid searching cur_pid+1, cur_pid+2, … with wrap modulo NUM_PROCS; cur_pid itself is checked last. From IDLE the search starts at pid 0.
- IDLE: base_addr=SO_BASE, user_mode=0, irq=0. If enable && |proc_valid, then next_pid ← picker result → IRQ. If proc_valid==0, stay in IDLE.
- RUN: user_mode=1. instr_retire decrements quantum_left, saturating at 0.
  - Expiry is the retire that moves quantum_left from 1→0.
  - On expiry with no exit: if picker==cur_pid (sole alive process), reload quantum_left=QUANTUM and stay in RUN with no irq. Otherwise next_pid ← picker → IRQ.
  - On proc_exit: clear the alive bit. If no process is left alive, go to IDLE, pulse all_done, base_addr=SO_BASE. Otherwise next_pid ← picker over the updated mask → IRQ.
  - If proc_exit and expiry occur in the same cycle, exit takes precedence.
- IRQ: irq=1, user_mode=0. On irq_ack go to SWITCH. cs_done is ignored in this state.
- SWITCH: irq=0. On cs_done: cur_pid ← next_pid, base_addr ← USER_BASE + next_pid*SLOT_SIZE, quantum_left ← QUANTUM, go to RUN.
- Outside RUN: instr_retire and proc_exit are ignored. enable is ignored outside IDLE.
- Base addresses: base_addr = USER_BASE + next_pid*SLOT_SIZE, computed at ADDR_WIDTH with zero-extended pid.
  - pid 0→2000, 1→3000, 2→4000, 3→5000, 4→6000.
  - No overflow occurs for the legal parameter range.

## Timing
- Reset values: irq=0, user_mode=0, cur_pid=0, next_pid=0, base_addr=SO_BASE (1000), quantum_left=0, all_done=0, alive=0.
- Expiry retire at cycle n → irq=1 at n+1.
- irq_ack at cycle m → irq=0 at m+1.
- cs_done at cycle k → cur_pid, base_addr, quantum_left and user_mode=1 all updated at k+1.
- IDLE start: enable at cycle n → irq=1 at n+1.
- proc_exit at cycle n → irq=1 or all_done=1 at n+1.
- Reset asserted in any state → all outputs return to reset values immediately (asynchronous), including a pending irq.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- sched_pkg holds:
  - State enum {IDLE, IRQ, SWITCH, RUN}.
  - Memory-map constants CS_BASE=0, SO_BASE=1000, USER_BASE=2000, SLOT_SIZE=1000.
- The same map constants are shared with the instruction-RAM loader.
- One sub-module, rr_picker: combinational round-robin first-set finder with inputs alive mask, start pid and from_idle flag, and outputs pid and found.

## Test plan
- Start: proc_valid=5'b00101, enable pulse → irq next cycle, next_pid=0; ack, cs_done → cur_pid=0, base_addr=2000, quantum_left=1000.
- Quantum: with QUANTUM=4, 4 retires in pid 0 → irq, next_pid=2; after switch, base_addr=4000; 4 more retires → next_pid=0.
- Sole process: proc_valid=5'b10000, expire quantum → no irq, quantum_left reloads to QUANTUM, cur_pid stays 4, base_addr stays 6000.
- Same-cycle exit: proc_exit and the expiring retire in the same cycle with alive={0,1} on pid 0 → alive=5'b00010, next_pid=1; then exit pid 1 → all_done pulse, state IDLE, base_addr=1000.
- Protocol: cs_done during IRQ is ignored; retires during SWITCH leave quantum_left unchanged; enable while in RUN has no effect.
- Reset: assert reset_n=0 while irq=1 → irq=0 and base_addr=1000 without waiting for a clock edge; after release, scheduling restarts only on enable.

Source files
------------

// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared scheduler state encoding and instruction-RAM memory map
//
// Purpose: FSM state enum for quantum_scheduler plus the memory-map constants
//          that the instruction-RAM loader also uses.
// Ports:   none (package).
package sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IRQ    = 2'd1,
        S_SWITCH = 2'd2,
        S_RUN    = 2'd3
    } sched_state_e;

    // Instruction-RAM memory map: context-switch routine, scheduler OS code,
    // then one fixed-size slot per user program.
    localparam int unsigned CS_BASE   = 0;
    localparam int unsigned SO_BASE   = 1000;
    localparam int unsigned USER_BASE = 2000;
    localparam int unsigned SLOT_SIZE = 1000;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin first-alive-process finder
//
// Purpose: returns the first set bit of alive searching start_pid+1,
//          start_pid+2, ... with wrap, start_pid itself last; when from_idle
//          is set the search is simply 0,1,2,...
// Ports:   alive     - candidate mask
//          start_pid - currently running pid (search origin)
//          from_idle - search from pid 0 instead of start_pid+1
//          pid       - selected pid (0 when nothing found)
//          found     - at least one candidate was alive
module rr_picker #(
    parameter int NUM_PROCS = 5,
    parameter int PID_WIDTH = 3
) (
    input  logic [NUM_PROCS-1:0] alive,
    input  logic [PID_WIDTH-1:0] start_pid,
    input  logic                 from_idle,
    output logic [PID_WIDTH-1:0] pid,
    output logic                 found
);

    // Constant-index bit select so a run-time int index never reaches the vector.
    function automatic logic bit_at(input logic [NUM_PROCS-1:0] m, input int idx);
        logic b;
        b = 1'b0;
        for (int j = 0; j < NUM_PROCS; j++) begin
            if (j == idx) b = m[j];
        end
        return b;
    endfunction

    always_comb begin
        pid   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_PROCS; i++) begin
            int cand;
            if (from_idle) begin
                cand = i;
            end else begin
                // start_pid < NUM_PROCS, so one subtraction is enough to wrap.
                cand = int'(start_pid) + 1 + i;
                if (cand >= NUM_PROCS) cand = cand - NUM_PROCS;
            end
            if (!found && bit_at(alive, cand)) begin
                found = 1'b1;
                pid   = PID_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/quantum_scheduler.sv
// rtl/quantum_scheduler.sv - preemptive round-robin scheduler for user-program slots
//
// Purpose: counts retired user instructions against a fixed quantum, raises
//          irq to enter the context-switch routine, selects the next process
//          and publishes its relocation base for the fetch path.
// Ports:   clock, reset_n (async, active low)
//          enable       - start scheduling (IDLE only)
//          proc_valid   - loaded-slot mask, captured when leaving IDLE
//          instr_retire - one pulse per retired user instruction
//          proc_exit    - running process halted
//          irq_ack      - CPU accepted irq
//          cs_done      - context-switch routine finished
//          irq, user_mode, cur_pid, next_pid, base_addr, quantum_left,
//          all_done     - registered status/control outputs
module quantum_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_PROCS  = 5,
    parameter int PID_WIDTH  = 3,
    parameter int QUANTUM    = 1000,
    parameter int ADDR_WIDTH = 32,
    parameter int QW         = $clog2(QUANTUM + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [NUM_PROCS-1:0]  proc_valid,
    input  logic                  instr_retire,
    input  logic                  proc_exit,
    input  logic                  irq_ack,
    input  logic                  cs_done,
    output logic                  irq,
    output logic                  user_mode,
    output logic [PID_WIDTH-1:0]  cur_pid,
    output logic [PID_WIDTH-1:0]  next_pid,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output logic [QW-1:0]         quantum_left,
    output logic                  all_done
);

    sched_state_e          state_q, state_d;
    logic [NUM_PROCS-1:0]  alive_q, alive_d;
    logic [PID_WIDTH-1:0]  cur_q, cur_d;
    logic [PID_WIDTH-1:0]  next_q, next_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [QW-1:0]         ql_q, ql_d;
    logic                  done_q, done_d;

    logic [NUM_PROCS-1:0]  alive_cleared;
    logic [NUM_PROCS-1:0]  pick_mask;
    logic [PID_WIDTH-1:0]  pick_pid;
    logic                  pick_found;
    logic                  expiry;

    localparam logic [ADDR_WIDTH-1:0] SO_ADDR = ADDR_WIDTH'(SO_BASE);

    function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [PID_WIDTH-1:0] p);
        return ADDR_WIDTH'(USER_BASE) + ADDR_WIDTH'(p) * ADDR_WIDTH'(SLOT_SIZE);
    endfunction

    assign alive_cleared = alive_q & ~(NUM_PROCS'(1) << cur_q);
    assign expiry        = instr_retire && (ql_q == QW'(1));

    // One picker serves every decision point: IDLE looks at the incoming
    // slot mask, an exit looks at the mask with the leaver already removed.
    always_comb begin
        pick_mask = alive_q;
        if (state_q == S_IDLE)  pick_mask = proc_valid;
        else if (proc_exit)     pick_mask = alive_cleared;
    end

    rr_picker #(
        .NUM_PROCS (NUM_PROCS),
        .PID_WIDTH (PID_WIDTH)
    ) u_picker (
        .alive     (pick_mask),
        .start_pid (cur_q),
        .from_idle (state_q == S_IDLE),
        .pid       (pick_pid),
        .found     (pick_found)
    );

    always_comb begin
        state_d = state_q;
        alive_d = alive_q;
        cur_d   = cur_q;
        next_d  = next_q;
        base_d  = base_q;
        ql_d    = ql_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                base_d = SO_ADDR;
                if (enable && pick_found) begin
                    alive_d = proc_valid;
                    next_d  = pick_pid;
                    state_d = S_IRQ;
                end
            end
            S_IRQ: begin
                if (irq_ack) state_d = S_SWITCH;
            end
            S_SWITCH: begin
                if (cs_done) begin
                    cur_d   = next_q;
                    base_d  = slot_base(next_q);
                    ql_d    = QW'(QUANTUM);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (instr_retire && (ql_q != '0)) ql_d = ql_q - QW'(1);
                // Exit outranks a simultaneous expiry.
                if (proc_exit) begin
                    alive_d = alive_cleared;
                    if (!pick_found) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        base_d  = SO_ADDR;
                    end else begin
                        next_d  = pick_pid;
                        state_d = S_IRQ;
                    end
                end else if (expiry) begin
                    // Sole survivor keeps the CPU without a context switch.
                    if (pick_pid == cur_q) begin
                        ql_d = QW'(QUANTUM);
                    end else begin
                        next_d  = pick_pid;
                        state_d = S_IRQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            alive_q <= '0;
            cur_q   <= '0;
            next_q  <= '0;
            base_q  <= SO_ADDR;
            ql_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= alive_d;
            cur_q   <= cur_d;
            next_q  <= next_d;
            base_q  <= base_d;
            ql_q    <= ql_d;
            done_q  <= done_d;
        end
    end

    // Pure decodes of the state register, so no input reaches an output directly.
    assign irq          = (state_q == S_IRQ);
    assign user_mode    = (state_q == S_RUN);
    assign cur_pid      = cur_q;
    assign next_pid     = next_q;
    assign base_addr    = base_q;
    assign quantum_left = ql_q;
    assign all_done     = done_q;

endmodule
